// File: rtl/shift_add_pkg.sv
// Shared types for the shift-and-subtract modular-reduction pipeline.
// One stage_t travels through each register slice of the pipeline.
package shift_add_pkg;

    localparam int unsigned WIDTH = 64;

    typedef logic [WIDTH-1:0] word_t;

    typedef struct packed {
        word_t r;
        word_t m;
        word_t m_bl;
        logic  v;
    } stage_t;

endpackage

// File: rtl/shift_add_stage.sv
// One reduction slice: subtract m << S from r when it fits, then register.
// Only the valid bit is reset; data flops are free-running.
module shift_add_stage
    import shift_add_pkg::*;
#(
    parameter int unsigned S = 0
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  stage_t stage_i,
    output stage_t stage_o
);

    logic [2*WIDTH-1:0] sub_w;
    stage_t             stage_d;
    stage_t             stage_q;

    always_comb begin
        // Double-width shifted modulus, so m << S can never wrap.
        sub_w   = {{WIDTH{1'b0}}, stage_i.m} << S;
        stage_d = stage_i;
        if ({{WIDTH{1'b0}}, stage_i.r} >= sub_w) begin
            stage_d.r = stage_i.r - sub_w[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_q.v <= 1'b0;
        end else begin
            stage_q.v <= stage_d.v;
        end
        stage_q.r    <= stage_d.r;
        stage_q.m    <= stage_d.m;
        stage_q.m_bl <= stage_d.m_bl;
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/shift_add_pipelined.sv
// Streaming x mod m: WIDTH reduction slices (S = WIDTH-1 .. 0) plus an output
// register that holds the last valid result across bubbles.
module shift_add_pipelined
    import shift_add_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] m_i,
    input  logic [WIDTH-1:0] m_bl_i,
    output logic [WIDTH-1:0] result_o,
    output logic             valid_o
);

    stage_t           pipe_w [WIDTH+1];
    logic [WIDTH-1:0] result_d, result_q;
    logic             valid_d, valid_q;
    logic             unused_tail;

    always_comb begin
        pipe_w[0].r    = x_i;
        pipe_w[0].m    = m_i;
        pipe_w[0].m_bl = m_bl_i;
        pipe_w[0].v    = start_i;
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        shift_add_stage #(
            .S(WIDTH - 1 - g)
        ) u_stage (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .stage_i(pipe_w[g]),
            .stage_o(pipe_w[g+1])
        );
    end

    // The modulus and its bit-length hint are not needed past the last slice.
    assign unused_tail = ^{pipe_w[WIDTH].m, pipe_w[WIDTH].m_bl};

    always_comb begin
        valid_d  = pipe_w[WIDTH].v;
        result_d = result_q;
        if (pipe_w[WIDTH].v) begin
            result_d = pipe_w[WIDTH].r;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
        end
    end

    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_shift_add_pipelined.sv
// Bench for shift_add_pipelined: a per-cycle scoreboard built from x % m plus
// directed scenarios with hand-computed results and arrival cycles.
module tb_shift_add_pipelined;

    localparam int unsigned W   = 64;
    localparam int unsigned LAT = 64;

    typedef struct {
        int          cyc;
        logic [63:0] res;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [63:0]   x_i = '0;
    logic [63:0]   m_i = '0;
    logic [63:0]   m_bl_i = '0;
    logic [63:0]   result_o;
    logic          valid_o;

    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    logic [63:0]   exp_map [int];
    logic [63:0]   last_res = '0;
    obs_t          obs [$];
    int            issue_cyc [$];

    shift_add_pipelined #(
        .WIDTH(W)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .start_i (start_i),
        .x_i     (x_i),
        .m_i     (m_i),
        .m_bl_i  (m_bl_i),
        .result_o(result_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mod(input logic [63:0] x, input logic [63:0] m);
        if (m == 64'd0) return x;
        return x % m;
    endfunction

    function automatic void check64(input string name, input logic [63:0] got,
                                    input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    // Model input side: what each rising edge commits.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_ni) begin
                exp_map.delete();
                last_res = '0;
            end else if (start_i) begin
                exp_map[cyc + LAT] = ref_mod(x_i, m_i);
            end
        end
    end

    // Compare process: every cycle, valid_o and result_o against the model.
    initial begin
        logic        ev;
        logic [63:0] er;
        forever begin
            @(negedge clk);
            if (exp_map.exists(cyc)) begin
                ev       = 1'b1;
                er       = exp_map[cyc];
                last_res = er;
                exp_map.delete(cyc);
            end else begin
                ev = 1'b0;
                er = last_res;
            end
            check64("valid_o", {63'd0, valid_o}, {63'd0, ev});
            check64("result_o", result_o, er);
            if (valid_o === 1'b1) obs.push_back('{cyc: cyc, res: result_o});
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one item for exactly one cycle.
    task automatic send(input logic [63:0] x, input logic [63:0] m, input logic [63:0] mbl);
        start_i = 1'b1;
        x_i     = x;
        m_i     = m;
        m_bl_i  = mbl;
        @(posedge clk);
        #1;
        issue_cyc.push_back(cyc);
        start_i = 1'b0;
        x_i     = $urandom();
    endtask

    task automatic check_obs(input string name, input int idx, input int want_cyc,
                             input logic [63:0] want_res);
        if (idx >= obs.size()) begin
            checks++;
            failures++;
            $display("FAIL %s: missing output #%0d (got %0d outputs)", name, idx, obs.size());
        end else begin
            check64({name, "_cycle"}, 64'(obs[idx].cyc), 64'(want_cyc));
            check64({name, "_value"}, obs[idx].res, want_res);
        end
    endtask

    task automatic check_count(input string name, input int want);
        check64({name, "_count"}, 64'(obs.size()), 64'(want));
    endtask

    task automatic clear_obs();
        obs.delete();
        issue_cyc.delete();
    endtask

    initial begin
        // Reset held with start_i high and garbage on the data inputs.
        rst_ni  = 1'b0;
        start_i = 1'b1;
        x_i     = 64'hDEAD_BEEF_0000_0001;
        m_i     = 64'd3;
        @(posedge clk);
        @(posedge clk);
        #1;
        check64("reset_result", result_o, 64'd0);
        start_i = 1'b0;
        rst_ni  = 1'b1;
        clear_obs();
        idle(70);
        check_count("post_reset_quiet", 0);

        // Single item.
        clear_obs();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF, 64'd31);
        idle(70);
        check_count("single", 1);
        check_obs("single", 0, issue_cyc[0] + 64, 64'h3);

        // Four back-to-back items, same modulus.
        clear_obs();
        send(64'h7FFF_FFFF, 64'h7FFF_FFFF, 64'd31);
        send(64'h8000_0000, 64'h7FFF_FFFF, 64'd31);
        send(64'h5, 64'h7FFF_FFFF, 64'd31);
        send(64'h1234_5678_9ABC_DEF0, 64'h7FFF_FFFF, 64'd31);
        idle(70);
        check_count("stream", 4);
        check_obs("stream0", 0, issue_cyc[0] + 64, 64'h0);
        check_obs("stream1", 1, issue_cyc[0] + 65, 64'h1);
        check_obs("stream2", 2, issue_cyc[0] + 66, 64'h5);
        check_obs("stream3", 3, issue_cyc[0] + 67, 64'h3F25_8BE1);

        // Bubbles: items at relative cycles 0, 2, 3.
        clear_obs();
        send(64'd10, 64'd3, 64'd2);
        idle(1);
        send(64'd11, 64'd3, 64'd2);
        send(64'd12, 64'd3, 64'd2);
        idle(70);
        check_count("bubble", 3);
        check_obs("bubble0", 0, issue_cyc[0] + 64, 64'd1);
        check_obs("bubble1", 1, issue_cyc[0] + 66, 64'd2);
        check_obs("bubble2", 2, issue_cyc[0] + 67, 64'd0);

        // Per-item modulus, including m = 0 and a deliberately wrong hint.
        clear_obs();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 64'd3);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, 64'd33);
        send(64'hABCD, 64'd0, 64'd0);
        send(64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF);
        idle(70);
        check_count("per_item", 4);
        check_obs("mod7", 0, issue_cyc[0] + 64, 64'h1);
        check_obs("mod2p32", 1, issue_cyc[0] + 65, 64'hFFFF_FFFF);
        check_obs("mod0", 2, issue_cyc[0] + 66, 64'hABCD);
        check_obs("bad_hint", 3, issue_cyc[0] + 67, 64'd2);

        // A few pseudo-random items checked by the scoreboard only.
        for (int i = 0; i < 6; i++) begin
            send({$urandom(), $urandom()}, {32'd0, $urandom()} >> (i * 4), 64'd0);
        end
        idle(70);

        // Reset with ten items in flight, then one fresh item.
        clear_obs();
        for (int i = 0; i < 10; i++) begin
            send(64'd1000 + 64'(i), 64'd13, 64'd4);
        end
        idle(20);
        rst_ni = 1'b0;
        idle(2);
        rst_ni = 1'b1;
        idle(80);
        check_count("flushed", 0);
        clear_obs();
        send(64'd1000, 64'd7, 64'd3);
        idle(70);
        check_count("after_flush", 1);
        check_obs("after_flush", 0, issue_cyc[0] + 64, 64'd6);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
